// File: rtl/calcutec_ctrl_pkg.sv
// Shared types and constants for the CalcuTEC host-side sequencer.
package calcutec_ctrl_pkg;

  localparam int CTRL_ADDR_W = 5;
  localparam int CTRL_DATA_W = 32;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_HOLD = 3'd4
  } state_t;

endpackage

// File: rtl/ctrl_down_counter.sv
// Loadable down counter with a zero flag; load has priority over decrement,
// and decrement saturates at zero.
module ctrl_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/calcutec_seq_ctrl.sv
// Host-side sequencer for the CalcuTEC core: loads the program, runs the core
// for a bounded number of cycles and streams data memory back to the host.
module calcutec_seq_ctrl
  import calcutec_ctrl_pkg::*;
#(
  parameter int ADDR_W = CTRL_ADDR_W,
  parameter int DATA_W = CTRL_DATA_W,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [CNT_W-1:0]  cmd_cycles,
  input  logic              abort,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [DATA_W-1:0] prog_data,
  output logic              write_ins,
  output logic [ADDR_W-1:0] ins_address,
  output logic [DATA_W-1:0] ins,
  output logic              cpu_run,
  output logic [ADDR_W-1:0] result_add,
  input  logic [DATA_W-1:0] resultado_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done
);

  localparam int LAT_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CYC_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CYC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LAT - 1);

  state_t state_r, state_nxt;
  logic [ADDR_W-1:0] addr_r, addr_nxt;

  logic accept_s, prog_hs_s, res_hs_s, abort_s, cmd_empty_s;
  logic wcnt_load_s, wcnt_dec_s, wcnt_zero_s;
  logic ccnt_load_s, ccnt_dec_s, ccnt_zero_s;
  logic lcnt_load_s, lcnt_dec_s, lcnt_zero_s;
  logic [ADDR_W:0] wcnt_val_s;

  logic              write_ins_nxt, cpu_run_nxt, res_valid_nxt, done_nxt;
  logic [ADDR_W-1:0] ins_address_nxt, result_add_nxt;
  logic [DATA_W-1:0] ins_nxt, res_data_nxt;

  assign accept_s  = cmd_valid & cmd_ready;
  assign prog_hs_s = prog_valid & prog_ready;
  assign res_hs_s  = res_valid & res_ready;
  assign abort_s   = abort & (state_r != ST_IDLE);
  assign cmd_empty_s = (cmd_op == OP_NOP) ||
                       ((cmd_op == OP_RUN) && (cmd_cycles == CYC_ZERO)) ||
                       ((cmd_op != OP_RUN) && (cmd_len == LEN_ZERO));

  ctrl_down_counter #(.WIDTH(ADDR_W+1)) u_word_cnt (
    .clk(clk), .rst_n(rst_n), .load(wcnt_load_s), .load_val(wcnt_val_s),
    .dec(wcnt_dec_s), .zero(wcnt_zero_s)
  );

  ctrl_down_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst_n(rst_n), .load(ccnt_load_s), .load_val(cmd_cycles - CYC_ONE),
    .dec(ccnt_dec_s), .zero(ccnt_zero_s)
  );

  ctrl_down_counter #(.WIDTH(LAT_W)) u_lat_cnt (
    .clk(clk), .rst_n(rst_n), .load(lcnt_load_s), .load_val(LAT_LOAD),
    .dec(lcnt_dec_s), .zero(lcnt_zero_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every busy state
  always_comb begin
    state_nxt = state_r;
    if (abort_s) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && !cmd_empty_s) begin
            case (cmd_op)
              OP_LOAD: state_nxt = ST_LOAD;
              OP_RUN:  state_nxt = ST_RUN;
              OP_READ: state_nxt = ST_RD_WAIT;
              default: state_nxt = ST_IDLE;
            endcase
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_LOAD:    state_nxt = wcnt_zero_s ? ST_IDLE : ST_LOAD;
        ST_RUN:     state_nxt = ccnt_zero_s ? ST_IDLE : ST_RUN;
        ST_RD_WAIT: state_nxt = lcnt_zero_s ? ST_RD_HOLD : ST_RD_WAIT;
        ST_RD_HOLD: begin
          if (res_hs_s) begin
            state_nxt = wcnt_zero_s ? ST_IDLE : ST_RD_WAIT;
          end else begin
            state_nxt = ST_RD_HOLD;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic: handshakes, counter control and next values of registered outputs
  always_comb begin
    cmd_ready       = (state_r == ST_IDLE);
    prog_ready      = (state_r == ST_LOAD) && !wcnt_zero_s && !abort;
    busy            = (state_r != ST_IDLE);
    write_ins_nxt   = 1'b0;
    cpu_run_nxt     = 1'b0;
    res_valid_nxt   = 1'b0;
    done_nxt        = 1'b0;
    ins_address_nxt = ins_address;
    ins_nxt         = ins;
    result_add_nxt  = result_add;
    res_data_nxt    = res_data;
    addr_nxt        = addr_r;
    wcnt_load_s     = 1'b0;
    wcnt_val_s      = cmd_len;
    wcnt_dec_s      = 1'b0;
    ccnt_load_s     = 1'b0;
    ccnt_dec_s      = 1'b0;
    lcnt_load_s     = 1'b0;
    lcnt_dec_s      = 1'b0;
    if (abort_s) begin
      done_nxt = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && cmd_empty_s) begin
            done_nxt = 1'b1;
          end else if (accept_s) begin
            addr_nxt = cmd_addr;
            case (cmd_op)
              OP_LOAD: wcnt_load_s = 1'b1;
              OP_RUN: begin
                ccnt_load_s = 1'b1;
                cpu_run_nxt = 1'b1;
              end
              OP_READ: begin
                // READ counts words left after the current one
                wcnt_load_s    = 1'b1;
                wcnt_val_s     = cmd_len - LEN_ONE;
                lcnt_load_s    = 1'b1;
                result_add_nxt = cmd_addr;
              end
              default: done_nxt = 1'b0;
            endcase
          end else begin
            done_nxt = 1'b0;
          end
        end
        ST_LOAD: begin
          if (prog_hs_s) begin
            write_ins_nxt   = 1'b1;
            ins_address_nxt = addr_r;
            ins_nxt         = prog_data;
            addr_nxt        = addr_r + ADDR_ONE;
            wcnt_dec_s      = 1'b1;
          end else if (wcnt_zero_s) begin
            done_nxt = 1'b1;
          end else begin
            write_ins_nxt = 1'b0;
          end
        end
        ST_RUN: begin
          if (ccnt_zero_s) begin
            done_nxt = 1'b1;
          end else begin
            cpu_run_nxt = 1'b1;
            ccnt_dec_s  = 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (lcnt_zero_s) begin
            res_valid_nxt = 1'b1;
            res_data_nxt  = resultado_out;
          end else begin
            lcnt_dec_s = 1'b1;
          end
        end
        ST_RD_HOLD: begin
          if (!res_hs_s) begin
            res_valid_nxt = 1'b1;
          end else if (wcnt_zero_s) begin
            done_nxt = 1'b1;
          end else begin
            addr_nxt       = addr_r + ADDR_ONE;
            result_add_nxt = addr_r + ADDR_ONE;
            wcnt_dec_s     = 1'b1;
            lcnt_load_s    = 1'b1;
          end
        end
        default: done_nxt = 1'b0;
      endcase
    end
  end

  // Registered outputs and working address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_ins   <= 1'b0;
      ins_address <= {ADDR_W{1'b0}};
      ins         <= {DATA_W{1'b0}};
      cpu_run     <= 1'b0;
      result_add  <= {ADDR_W{1'b0}};
      res_valid   <= 1'b0;
      res_data    <= {DATA_W{1'b0}};
      done        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
    end else begin
      write_ins   <= write_ins_nxt;
      ins_address <= ins_address_nxt;
      ins         <= ins_nxt;
      cpu_run     <= cpu_run_nxt;
      result_add  <= result_add_nxt;
      res_valid   <= res_valid_nxt;
      res_data    <= res_data_nxt;
      done        <= done_nxt;
      addr_r      <= addr_nxt;
    end
  end

endmodule

// File: tb/tb_calcutec_seq_ctrl.sv
// Directed bench for calcutec_seq_ctrl with instruction/data memory models
// (data memory read latency of two cycles).
module tb_calcutec_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [5:0]  cmd_len;
  logic [15:0] cmd_cycles;
  logic        abort, prog_valid, prog_ready;
  logic [31:0] prog_data;
  logic        write_ins, cpu_run, res_valid, res_ready, busy, done;
  logic [4:0]  ins_address, result_add;
  logic [31:0] ins, resultado_out, res_data;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] imem [32];
  logic [31:0] dmem [32];
  logic [4:0]  rd_addr_d = 5'd0;

  calcutec_seq_ctrl #(.ADDR_W(5), .DATA_W(32), .CNT_W(16), .RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_cycles(cmd_cycles),
    .abort(abort), .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_data(prog_data),
    .write_ins(write_ins), .ins_address(ins_address), .ins(ins), .cpu_run(cpu_run),
    .result_add(result_add), .resultado_out(resultado_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_ins) imem[ins_address] <= ins;
    rd_addr_d <= result_add;
  end
  assign resultado_out = dmem[rd_addr_d];

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] addr,
                          input logic [5:0] len, input logic [15:0] cycles);
    check_eq("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_cycles = cycles;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 20) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    logic [31:0] words [4];
    logic [4:0]  waddr [4];
    logic [31:0] rdexp [3];
    int n;
    words = '{32'hE3A01005, 32'hE2811001, 32'hE5801000, 32'hEAFFFFFE};
    waddr = '{5'd30, 5'd31, 5'd0, 5'd1};
    rdexp = '{32'h5, 32'h6, 32'h7};
    for (int i = 0; i < 32; i++) begin
      dmem[i] = 32'hA000_0000 + 32'(i);
      imem[i] = 32'h0;
    end
    dmem[0] = 32'h5; dmem[1] = 32'h6; dmem[2] = 32'h7;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 5'd0; cmd_len = 6'd0;
    cmd_cycles = 16'd0; abort = 1'b0; prog_valid = 1'b0; prog_data = 32'd0; res_ready = 1'b0;
    repeat (3) cyc();
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    check_eq("rst_write_ins", {31'd0, write_ins}, 32'd0);
    check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // LOAD with address wrap
    send_cmd(2'b00, 5'd30, 6'd4, 16'd0);
    check_eq("load_busy", {31'd0, busy}, 32'd1);
    check_eq("load_prog_ready", {31'd0, prog_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      prog_valid = 1'b1; prog_data = words[k];
      cyc();
      check_eq("load_wr", {31'd0, write_ins}, 32'd1);
      check_eq("load_addr", {27'd0, ins_address}, {27'd0, waddr[k]});
      check_eq("load_data", ins, words[k]);
      check_eq("load_no_done", {31'd0, done}, 32'd0);
    end
    prog_valid = 1'b0;
    #1 check_eq("load_prog_ready_end", {31'd0, prog_ready}, 32'd0);
    cyc();
    check_eq("load_done", {31'd0, done}, 32'd1);
    check_eq("load_wr_off", {31'd0, write_ins}, 32'd0);
    check_eq("load_idle", {31'd0, busy}, 32'd0);
    check_eq("imem_31", imem[31], words[1]);
    cyc();
    check_eq("load_done_pulse", {31'd0, done}, 32'd0);
    check_eq("imem_1", imem[1], words[3]);

    // RUN 10 cycles
    send_cmd(2'b01, 5'd0, 6'd0, 16'd10);
    n = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (cpu_run) n++;
      cyc();
    end
    check_eq("run10_len", 32'(n), 32'd10);
    check_eq("run10_done", {31'd0, done}, 32'd1);
    check_eq("run10_run_off", {31'd0, cpu_run}, 32'd0);
    cyc();

    // RUN 0, LOAD len 0 and reserved opcode complete immediately
    send_cmd(2'b01, 5'd0, 6'd0, 16'd0);
    check_eq("run0_done", {31'd0, done}, 32'd1);
    check_eq("run0_run", {31'd0, cpu_run}, 32'd0);
    check_eq("run0_busy", {31'd0, busy}, 32'd0);
    cyc();
    send_cmd(2'b00, 5'd4, 6'd0, 16'd0);
    check_eq("load0_done", {31'd0, done}, 32'd1);
    check_eq("load0_wr", {31'd0, write_ins}, 32'd0);
    cyc();
    send_cmd(2'b11, 5'd0, 6'd3, 16'd3);
    check_eq("nop_done", {31'd0, done}, 32'd1);
    check_eq("nop_busy", {31'd0, busy}, 32'd0);
    cyc();

    // READ 3 words with a stall on word 1
    send_cmd(2'b10, 5'd0, 6'd3, 16'd0);
    for (int k = 0; k < 3; k++) begin
      wait_valid(n);
      check_eq("rd_latency", 32'(n), 32'd2);
      check_eq("rd_data", res_data, rdexp[k]);
      if (k == 1) begin
        for (int s = 0; s < 4; s++) begin
          cyc();
          check_eq("rd_stall_valid", {31'd0, res_valid}, 32'd1);
          check_eq("rd_stall_data", res_data, rdexp[1]);
        end
      end
      res_ready = 1'b1;
      cyc();
      res_ready = 1'b0;
      check_eq("rd_valid_drop", {31'd0, res_valid}, 32'd0);
      check_eq("rd_done", {31'd0, done}, (k == 2) ? 32'd1 : 32'd0);
      check_eq("rd_busy", {31'd0, busy}, (k == 2) ? 32'd0 : 32'd1);
    end
    cyc();

    // Abort RUN during its third cycle
    send_cmd(2'b01, 5'd0, 6'd0, 16'd100);
    cyc(); cyc();
    check_eq("abort_pre_run", {31'd0, cpu_run}, 32'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check_eq("abort_run", {31'd0, cpu_run}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    cyc();
    check_eq("abort_done_later", {31'd0, done}, 32'd0);
    send_cmd(2'b00, 5'd5, 6'd1, 16'd0);
    prog_valid = 1'b1; prog_data = 32'hCAFE_0005;
    cyc();
    prog_valid = 1'b0;
    check_eq("post_abort_addr", {27'd0, ins_address}, 32'd5);
    check_eq("post_abort_data", ins, 32'hCAFE_0005);
    cyc();
    check_eq("post_abort_done", {31'd0, done}, 32'd1);
    cyc();

    // Reset in the middle of a 5-word LOAD
    send_cmd(2'b00, 5'd10, 6'd5, 16'd0);
    for (int k = 0; k < 2; k++) begin
      prog_valid = 1'b1; prog_data = 32'h1111_0000 + 32'(k);
      cyc();
    end
    prog_valid = 1'b0;
    cyc();
    prog_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_prog_ready", {31'd0, prog_ready}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_wr", {31'd0, write_ins}, 32'd0);
    check_eq("mid_rst_addr", {27'd0, ins_address}, 32'd0);
    check_eq("partial_imem_10", imem[10], 32'h1111_0000);
    check_eq("partial_imem_11", imem[11], 32'h1111_0001);
    prog_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    send_cmd(2'b00, 5'd0, 6'd2, 16'd0);
    for (int k = 0; k < 2; k++) begin
      prog_valid = 1'b1; prog_data = 32'h2222_0000 + 32'(k);
      cyc();
      check_eq("reload_addr", {27'd0, ins_address}, 32'(k));
      check_eq("reload_data", ins, 32'h2222_0000 + 32'(k));
    end
    prog_valid = 1'b0;
    cyc();
    check_eq("reload_done", {31'd0, done}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
